// File: rtl/modulo_cod_coluna_pkg.sv
// Shared definitions for the column-coordinate encoder and the column decoder.
// Holds FSM state encodings, coordinate/code widths, the special "none" values
// and the inverse (code -> coordinate) mapping used by the display path.
package modulo_cod_coluna_pkg;

  localparam int unsigned CDC_W = 4;  // column coordinate width
  localparam int unsigned MDC_W = 3;  // column code width
  localparam int unsigned CNT_W = 8;  // error counter width

  localparam logic [CDC_W-1:0] COL_MAX  = 4'd4;
  localparam logic [CDC_W-1:0] CDC_NONE = 4'b1111;
  localparam logic [MDC_W-1:0] MDC_NONE = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    HOLD  = 2'd2,
    ERR   = 2'd3
  } state_t;

  // Result of encoding one coordinate
  typedef struct packed {
    logic             valid;
    logic [MDC_W-1:0] code;
  } col_enc_t;

  // Column decoder: code -> coordinate (111 means none/saturated)
  function automatic logic [CDC_W-1:0] decode_col(input logic [MDC_W-1:0] mdc);
    if (mdc == MDC_NONE) return CDC_NONE;
    return CDC_W'(mdc);
  endfunction

endpackage

// File: rtl/modulo_cod_coluna_if.sv
// Bus between the pushbutton/consumer side and the column encoder.
//   cdc       : column coordinate (to encoder)
//   ld        : asynchronous load request level (to encoder)
//   ack       : consumer acknowledge (to encoder)
//   mdc       : encoded column code (from encoder)
//   mdc_valid : mdc holds a fresh code awaiting ack (from encoder)
//   erro      : last capture was an invalid coordinate (from encoder)
interface modulo_cod_coluna_if;
  import modulo_cod_coluna_pkg::*;

  logic [CDC_W-1:0] cdc;
  logic             ld;
  logic             ack;
  logic [MDC_W-1:0] mdc;
  logic             mdc_valid;
  logic             erro;

  modport master (
    output cdc, ld, ack,
    input  mdc, mdc_valid, erro
  );

  modport slave (
    input  cdc, ld, ack,
    output mdc, mdc_valid, erro
  );
endinterface

// File: rtl/detector_borda.sv
// Two-flop synchronizer plus registered rising-edge detector.
//   clk, rst : clock and synchronous active-high reset
//   i_lvl    : asynchronous input level
//   o_pulse  : one-cycle pulse on a low->high transition of i_lvl
// A pulse is only produced after the synchronized level has been seen low at
// least once since reset, so a level held high through reset never fires.
module detector_borda (
  input  logic clk,
  input  logic rst,
  input  logic i_lvl,
  output logic o_pulse
);

  logic r_s1;
  logic r_s2;
  logic r_dly;
  logic r_v1;     // r_s1 holds a real sample (not a reset value)
  logic r_v2;     // r_s2 holds a real sample
  logic r_arm;    // real low level observed since reset
  logic r_pulse;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_dly   <= 1'b0;
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_arm   <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_s1    <= i_lvl;
      r_s2    <= r_s1;
      r_dly   <= r_s2;
      r_v1    <= 1'b1;
      r_v2    <= r_v1;
      if (r_v2 && !r_s2) r_arm <= 1'b1;
      r_pulse <= r_s2 & ~r_dly & r_arm;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/modulo_cod_coluna.sv
// Column-coordinate encoder: captures cdc on a synchronized ld rising edge,
// validates it and presents the 3-bit code with a valid/ack handshake, or
// raises erro for ERR_CYCLES cycles on an invalid coordinate.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of modulo_cod_coluna_if (cdc, ld, ack in;
//              mdc, mdc_valid, erro out)
module modulo_cod_coluna
  import modulo_cod_coluna_pkg::*;
#(
  parameter int unsigned ERR_CYCLES = 4  // legal 1..255
) (
  input  logic                 clk,
  input  logic                 rst,
  modulo_cod_coluna_if.slave   bus
);

  state_t           r_state;
  logic [CDC_W-1:0] r_cdc;
  logic [MDC_W-1:0] r_mdc;
  logic             r_mdc_valid;
  logic             r_erro;
  logic [CNT_W-1:0] r_cnt;

  logic             w_ld_pulse;
  col_enc_t         w_enc;

  // Coordinate -> code; 0..COL_MAX map directly, CDC_NONE maps to MDC_NONE
  function automatic col_enc_t encode_col(input logic [CDC_W-1:0] cdc);
    col_enc_t res;
    res.valid = 1'b0;
    res.code  = MDC_W'(cdc);
    if (cdc <= COL_MAX) begin
      res.valid = 1'b1;
    end else if (cdc == CDC_NONE) begin
      res.valid = 1'b1;
      res.code  = MDC_NONE;
    end
    return res;
  endfunction

  detector_borda u_det_ld (
    .clk     (clk),
    .rst     (rst),
    .i_lvl   (bus.ld),
    .o_pulse (w_ld_pulse)
  );

  assign w_enc = encode_col(r_cdc);

  // Control FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cdc       <= '0;
      r_mdc       <= '0;
      r_mdc_valid <= 1'b0;
      r_erro      <= 1'b0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_ld_pulse) begin
            r_cdc   <= bus.cdc;
            r_state <= CHECK;
          end
        end
        CHECK: begin
          if (w_enc.valid) begin
            r_mdc       <= w_enc.code;
            r_mdc_valid <= 1'b1;
            r_state     <= HOLD;
          end else begin
            r_cnt   <= CNT_W'(ERR_CYCLES);
            r_erro  <= 1'b1;
            r_state <= ERR;
          end
        end
        HOLD: begin
          if (bus.ack) begin
            r_mdc_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        ERR: begin
          // Counter was loaded with ERR_CYCLES on entry; leave on the last cycle
          if (r_cnt == CNT_W'(1)) begin
            r_erro  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.mdc       = r_mdc;
  assign bus.mdc_valid = r_mdc_valid;
  assign bus.erro      = r_erro;

endmodule

// File: tb/tb_modulo_cod_coluna.sv
// Directed self-checking bench for modulo_cod_coluna (ERR_CYCLES = 4).
module tb_modulo_cod_coluna;
  import modulo_cod_coluna_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  modulo_cod_coluna_if bus ();

  modulo_cod_coluna #(.ERR_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Raise ld just after an edge (next edge is E0); returns just after E4, ld low
  task automatic press(input logic [3:0] c);
    bus.cdc = c;
    bus.ld  = 1'b1;
    repeat (4) tick();
    check("lat_e3_valid", 8'(bus.mdc_valid), 8'h0);
    tick();
    bus.ld = 1'b0;
  endtask

  task automatic do_valid(input logic [3:0] c, input logic [2:0] exp_mdc);
    press(c);
    check("mdc", 8'(bus.mdc), 8'(exp_mdc));
    check("mdc_valid", 8'(bus.mdc_valid), 8'h1);
    check("erro_in_hold", 8'(bus.erro), 8'h0);
    check("round_trip", 8'(decode_col(bus.mdc)), 8'(c));
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    check("valid_after_ack", 8'(bus.mdc_valid), 8'h0);
    check("mdc_after_ack", 8'(bus.mdc), 8'(exp_mdc));
    repeat (3) tick();
  endtask

  task automatic do_err(input logic [3:0] c, input logic [2:0] prev_mdc);
    press(c);
    check("erro_c1", 8'(bus.erro), 8'h1);
    check("valid_in_err", 8'(bus.mdc_valid), 8'h0);
    check("mdc_kept_err", 8'(bus.mdc), 8'(prev_mdc));
    for (int i = 0; i < 3; i++) begin
      tick();
      check("erro_hold", 8'(bus.erro), 8'h1);
      check("valid_in_err", 8'(bus.mdc_valid), 8'h0);
    end
    tick();
    check("erro_end", 8'(bus.erro), 8'h0);
    check("mdc_after_err", 8'(bus.mdc), 8'(prev_mdc));
    repeat (3) tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus.cdc  = 4'h0;
    bus.ld   = 1'b0;
    bus.ack  = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_mdc", 8'(bus.mdc), 8'h0);
    check("rst_valid", 8'(bus.mdc_valid), 8'h0);
    check("rst_erro", 8'(bus.erro), 8'h0);
    rst = 1'b0;
    repeat (4) tick();

    // Basic capture of 0011, ack not yet asserted keeps valid up
    press(4'b0011);
    check("b_mdc", 8'(bus.mdc), 8'h3);
    check("b_valid", 8'(bus.mdc_valid), 8'h1);
    check("b_erro", 8'(bus.erro), 8'h0);
    repeat (2) tick();
    check("b_valid_wait", 8'(bus.mdc_valid), 8'h1);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    check("b_valid_ack", 8'(bus.mdc_valid), 8'h0);
    check("b_mdc_ack", 8'(bus.mdc), 8'h3);
    repeat (3) tick();

    // Valid coordinates: saturated code then sweep 0..4
    do_valid(4'b1111, 3'b111);
    do_valid(4'b0000, 3'b000);
    do_valid(4'b0001, 3'b001);
    do_valid(4'b0010, 3'b010);
    do_valid(4'b0011, 3'b011);
    do_valid(4'b0100, 3'b100);

    // Invalid coordinates keep last code (100)
    do_err(4'b0110, 3'b100);
    do_err(4'b1000, 3'b100);

    // ld held high ~20 cycles: exactly one capture
    bus.cdc = 4'b0001;
    bus.ld  = 1'b1;
    repeat (5) tick();
    check("hold_ld_mdc", 8'(bus.mdc), 8'h1);
    check("hold_ld_valid", 8'(bus.mdc_valid), 8'h1);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    check("hold_ld_ack", 8'(bus.mdc_valid), 8'h0);
    repeat (14) tick();
    check("hold_ld_no_recapture", 8'(bus.mdc_valid), 8'h0);
    check("hold_ld_no_err", 8'(bus.erro), 8'h0);
    bus.ld = 1'b0;
    repeat (3) tick();

    // Second ld rise during HOLD is dropped
    press(4'b0010);
    check("drop_first_mdc", 8'(bus.mdc), 8'h2);
    repeat (3) tick();
    bus.cdc = 4'b0100;
    bus.ld  = 1'b1;
    repeat (6) tick();
    check("drop_mdc", 8'(bus.mdc), 8'h2);
    check("drop_valid", 8'(bus.mdc_valid), 8'h1);
    bus.ld  = 1'b0;
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    check("drop_ack", 8'(bus.mdc_valid), 8'h0);
    repeat (3) tick();
    tick();
    check("drop_no_queue", 8'(bus.mdc_valid), 8'h0);
    press(4'b0100);
    check("new_cap_mdc", 8'(bus.mdc), 8'h4);
    check("new_cap_valid", 8'(bus.mdc_valid), 8'h1);

    // Reset while in HOLD
    rst = 1'b1;
    tick();
    check("rst_hold_valid", 8'(bus.mdc_valid), 8'h0);
    check("rst_hold_mdc", 8'(bus.mdc), 8'h0);
    check("rst_hold_erro", 8'(bus.erro), 8'h0);
    rst = 1'b0;
    repeat (4) tick();

    // Reset while in ERR
    press(4'b0111);
    check("pre_rst_err", 8'(bus.erro), 8'h1);
    rst = 1'b1;
    tick();
    check("rst_err_erro", 8'(bus.erro), 8'h0);
    check("rst_err_valid", 8'(bus.mdc_valid), 8'h0);
    check("rst_err_mdc", 8'(bus.mdc), 8'h0);

    // ld high across reset release: no capture until low then high
    bus.cdc = 4'b0001;
    bus.ld  = 1'b1;
    tick();
    rst = 1'b0;
    repeat (10) tick();
    check("ld_thru_rst_valid", 8'(bus.mdc_valid), 8'h0);
    check("ld_thru_rst_erro", 8'(bus.erro), 8'h0);
    bus.ld = 1'b0;
    repeat (4) tick();
    press(4'b0001);
    check("after_rst_mdc", 8'(bus.mdc), 8'h1);
    check("after_rst_valid", 8'(bus.mdc_valid), 8'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
